// File: rtl/handshake_const_check.sv
// handshake_const_check: elastic sink that compares each accepted token against
// a constant, emits a 1-bit match token through a 2-entry buffer and keeps a
// saturating mismatch counter.
// Optional first-mismatch capture is built when HANDSHAKE_CONST_CHECK_CAPTURE_EN
// is defined; otherwise err_valid/err_data are tied to zero.
module handshake_const_check #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [31:0] CONST_VALUE = 32'hE4E,
    parameter int unsigned CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  err_valid,
    output logic [DATA_WIDTH-1:0] err_data
);

    localparam logic [DATA_WIDTH-1:0] EXPECTED = DATA_WIDTH'(CONST_VALUE);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t                 occ;
    occ_t                 occ_nxt;
    logic                 slot0;
    logic                 slot1;
    logic                 slot0_nxt;
    logic                 slot1_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 accept;
    logic                 pop;
    logic                 result;

    assign accept = ins_valid & ins_ready;
    assign pop    = outs_valid & outs_ready;
    assign result = (ins == EXPECTED);

    // slot0 is always the head entry, so it drives outs directly
    assign outs = slot0;

    // Next occupancy, buffer contents and counter value
    always_comb begin
        occ_nxt   = occ;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        cnt_nxt   = mismatch_count;

        case (occ)
            OCC_EMPTY: begin
                if (accept) begin
                    slot0_nxt = result;
                    occ_nxt   = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    slot0_nxt = result;
                end else if (accept) begin
                    slot1_nxt = result;
                    occ_nxt   = OCC_FULL;
                end else if (pop) begin
                    occ_nxt   = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // ins_ready is low here, so only a pop can happen
                if (pop) begin
                    slot0_nxt = slot1;
                    occ_nxt   = OCC_ONE;
                end
            end
            default: begin
                occ_nxt = OCC_EMPTY;
            end
        endcase

        if (accept && !result && (mismatch_count != CNT_MAX)) begin
            cnt_nxt = mismatch_count + CNT_WIDTH'(1);
        end
    end

    // State register; handshake flags are precomputed from next occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ            <= OCC_EMPTY;
            slot0          <= 1'b0;
            slot1          <= 1'b0;
            ins_ready      <= 1'b0;
            outs_valid     <= 1'b0;
            mismatch_count <= '0;
        end else begin
            occ            <= occ_nxt;
            slot0          <= slot0_nxt;
            slot1          <= slot1_nxt;
            ins_ready      <= (occ_nxt != OCC_FULL);
            outs_valid     <= (occ_nxt != OCC_EMPTY);
            mismatch_count <= cnt_nxt;
        end
    end

`ifdef HANDSHAKE_CONST_CHECK_CAPTURE_EN
    // Capture the first mismatching token after reset and hold it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_valid <= 1'b0;
            err_data  <= '0;
        end else if (accept && !result && !err_valid) begin
            err_valid <= 1'b1;
            err_data  <= ins;
        end
    end
`else
    assign err_valid = 1'b0;
    assign err_data  = '0;
`endif

endmodule

// File: tb/tb_handshake_const_check.sv
// Scoreboard bench for handshake_const_check: expected match bits are queued
// on each accept and compared on each output pop; the mismatch counter is
// tracked by a small model. A second instance with CNT_WIDTH=2 covers
// counter saturation.
module tb_handshake_const_check;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam logic [31:0] K  = 32'hE4E;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] ins;
    logic          ins_valid;
    logic          ins_ready;
    logic          outs;
    logic          outs_valid;
    logic          outs_ready;
    logic [CW-1:0] mismatch_count;
    logic          err_valid;
    logic [DW-1:0] err_data;

    logic [DW-1:0] sat_ins;
    logic          sat_ins_valid;
    logic          sat_ins_ready;
    logic          sat_outs;
    logic          sat_outs_valid;
    logic          sat_outs_ready;
    logic [1:0]    sat_count;
    logic          sat_err_valid;
    logic [DW-1:0] sat_err_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int model_cnt = 0;
    int acc_cnt = 0;
    int pop_cnt = 0;
    int first_acc_cyc = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc  = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    handshake_const_check #(
        .DATA_WIDTH (DW),
        .CONST_VALUE(K),
        .CNT_WIDTH  (CW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .ins           (ins),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .outs          (outs),
        .outs_valid    (outs_valid),
        .outs_ready    (outs_ready),
        .mismatch_count(mismatch_count),
        .err_valid     (err_valid),
        .err_data      (err_data)
    );

    handshake_const_check #(
        .DATA_WIDTH (DW),
        .CONST_VALUE(K),
        .CNT_WIDTH  (2)
    ) u_sat (
        .clk           (clk),
        .rst           (rst),
        .ins           (sat_ins),
        .ins_valid     (sat_ins_valid),
        .ins_ready     (sat_ins_ready),
        .outs          (sat_outs),
        .outs_valid    (sat_outs_valid),
        .outs_ready    (sat_outs_ready),
        .mismatch_count(sat_count),
        .err_valid     (sat_err_valid),
        .err_data      (sat_err_data)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && (exp_q.size() != 0 || outs_valid); i++) step();
        check("drain_queue", 64'(exp_q.size()), 64'd0);
        check("drain_outs_valid", 64'(outs_valid), 64'd0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: sample away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            check("count", 64'(mismatch_count), 64'(model_cnt));
            if (outs_valid && outs_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pop", 64'(outs_valid), 64'd0);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    check("outs", 64'(outs), 64'(e));
                end
                if (pop_cnt == 0) first_pop_cyc = cyc;
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (ins_valid && ins_ready) begin
                exp_q.push_back(ins == K);
                if (ins != K && model_cnt < 255) model_cnt++;
                if (acc_cnt == 0) first_acc_cyc = cyc;
                acc_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        ins            = K;
        ins_valid      = 1'b1;
        outs_ready     = 1'b0;
        sat_ins        = '0;
        sat_ins_valid  = 1'b0;
        sat_outs_ready = 1'b1;

        // Reset with ins_valid high
        repeat (2) @(negedge clk);
        check("rst_ins_ready", 64'(ins_ready), 64'd0);
        check("rst_outs_valid", 64'(outs_valid), 64'd0);
        check("rst_outs", 64'(outs), 64'd0);
        check("rst_count", 64'(mismatch_count), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        #2;
        rst       = 1'b1;
        ins_valid = 1'b0;
        step();
        check("release_ins_ready", 64'(ins_ready), 64'd1);

        // Streaming 10 matching tokens
        outs_ready = 1'b1;
        acc_cnt    = 0;
        pop_cnt    = 0;
        ins        = K;
        ins_valid  = 1'b1;
        repeat (10) step();
        ins_valid = 1'b0;
        repeat (3) step();
        check("stream_accepts", 64'(acc_cnt), 64'd10);
        check("stream_pops", 64'(pop_cnt), 64'd10);
        check("stream_latency", 64'(first_pop_cyc - first_acc_cyc), 64'd1);
        check("stream_span", 64'(last_pop_cyc - first_acc_cyc), 64'd10);
        check("stream_count", 64'(mismatch_count), 64'd0);

        // Backpressure: fill buffer, then drain in order
        outs_ready = 1'b0;
        acc_cnt    = 0;
        ins_valid  = 1'b1;
        ins        = K;
        step();
        ins = 32'h0;
        step();
        check("bp_full_ins_ready", 64'(ins_ready), 64'd0);
        ins = 32'h777;
        repeat (3) begin
            step();
            check("bp_hold_valid", 64'(outs_valid), 64'd1);
            check("bp_hold_outs", 64'(outs), 64'd1);
            check("bp_hold_ready", 64'(ins_ready), 64'd0);
        end
        ins_valid = 1'b0;
        check("bp_accepts", 64'(acc_cnt), 64'd2);
        outs_ready = 1'b1;
        wait_drain();
        check("bp_count", 64'(mismatch_count), 64'd1);

        // Reset while the buffer is full
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins        = 32'h0;
        step();
        ins = K;
        step();
        ins_valid = 1'b0;
        check("mid_full", 64'(ins_ready), 64'd0);
        check("mid_pre_count", 64'(mismatch_count), 64'd2);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(outs_valid), 64'd0);
        check("mid_rst_count", 64'(mismatch_count), 64'd0);
        check("mid_rst_ready", 64'(ins_ready), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        rst        = 1'b1;
        outs_ready = 1'b1;
        pop_cnt    = 0;
        repeat (4) step();
        check("mid_no_stale_pop", 64'(pop_cnt), 64'd0);
        check("mid_no_stale_valid", 64'(outs_valid), 64'd0);

        // First-mismatch capture
        check("cap_before", 64'(err_valid), 64'd0);
        ins_valid = 1'b1;
        ins       = K;
        step();
        ins = 32'h123;
        step();
        ins = 32'h456;
        step();
        ins_valid = 1'b0;
        step();
`ifdef HANDSHAKE_CONST_CHECK_CAPTURE_EN
        check("cap_err_valid", 64'(err_valid), 64'd1);
        check("cap_err_data", 64'(err_data), 64'h123);
`else
        check("cap_err_valid", 64'(err_valid), 64'd0);
        check("cap_err_data", 64'(err_data), 64'd0);
`endif
        wait_drain();
        check("cap_count", 64'(mismatch_count), 64'd2);

        // Saturation with a 2-bit counter
        check("sat_ready", 64'(sat_ins_ready), 64'd1);
        sat_ins       = 32'h1;
        sat_ins_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int e;
            step();
            e = (k + 1 > 3) ? 3 : k + 1;
            check($sformatf("sat_count_%0d", k), 64'(sat_count), 64'(e));
        end
        sat_ins_valid = 1'b0;
        repeat (2) step();
        check("sat_hold", 64'(sat_count), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
